instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch sequencer that drives the 6-bit opcode bus into the main control decoder. It consumes the decoder's `Branch` output together with the ALU `Zero` flag to choose the next PC. It owns the PC, issues one-outstanding word reads to instruction memory over a valid/ready request and valid response interface, and holds each fetched instruction until the downstream stage accepts it. It sits between instruction memory and the decode stage of the MIPS datapath.

## Interface
- `PC_W`, 32: PC and address width; bits [1:0] are always 0.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `fetch_en` input 1: when 0, no new request is issued; an in-flight fetch still completes.
- `imem_req_valid` output 1: request valid.
- `imem_req_ready` input 1: memory accepts the request this cycle.
- `imem_req_addr` output PC_W: byte address of the word to fetch.
- `imem_rsp_valid` input 1: response data valid; exactly one response per accepted request.
- `imem_rsp_data` input 32: fetched instruction word.
- `instr_valid` output 1: `instr`, `instr_pc` and `Op` are meaningful.
- `instr_ready` input 1: downstream accepts the held instruction.
- `instr` output 32: held instruction register (IR).
- `instr_pc` output PC_W: address of the held instruction.
- `Op` output 6: IR[31:26] when `instr_valid`=1, else 6'b111111. 6'b111111 decodes to all-zero controls, acting as a bubble.
- `Branch` input 1: decoder output, evaluated combinationally from `Op`.
- `Zero` input 1: ALU zero flag for the held instruction, valid in the same cycle.
- `fetch_count` output 16: number of instructions accepted downstream; wraps modulo 2^16.

## Operation
- State machine has three states: FETCH, WAIT, HOLD.
- **FETCH**
  - `imem_req_valid` = `fetch_en`; `imem_req_addr` = pc.
  - `imem_req_valid` & `imem_req_ready` -> WAIT.
  - Otherwise stay in FETCH.
  - `imem_req_valid` must not drop, and `imem_req_addr` must not change, while the request is pending.
  - If `fetch_en` is 0, the unit does not assert `imem_req_valid`, so no request is pending.
- **WAIT**
  - `imem_req_valid`=0.
  - On `imem_rsp_valid`: IR <= `imem_rsp_data`, `instr_pc` <= pc, then -> HOLD.
- **HOLD**
  - `instr_valid`=1.
  - On `instr_ready`: `fetch_count` += 1, update pc as below, then -> FETCH.
- Next-PC rules:
  - seq = `instr_pc` + 4.
  - If `Branch` & `Zero`: pc <= seq + (sign_extend(IR[15:0]) << 2).
  - Else pc <= seq.
  - All address arithmetic is modulo 2^PC_W. Wrap from 0xFFFF_FFFC to 0 is legal.
  - `Branch`/`Zero` are sampled only in the HOLD cycle where `instr_ready`=1; they are ignored in all other cycles.
- `imem_rsp_valid` outside WAIT is ignored: no capture and no state change.
- `fetch_en` low in HOLD does not block acceptance; it only gates the next request in FETCH.

## Timing
- Reset (asynchronous, immediate):
  - state=FETCH, pc=`RESET_PC`.
  - IR=0, `instr_pc`=0, `fetch_count`=0.
  - `instr_valid`=0, `Op`=6'b111111, `imem_req_valid`=0 while `reset` is asserted.
- Minimum throughput is 3 cycles per instruction: request accepted (cycle 0), response (cycle 1 at earliest), accepted downstream (cycle 2), next request in cycle 3.
- Responses with zero added latency: a response in the cycle after request acceptance is captured in that cycle, giving `instr_valid` the next cycle.
- Reset mid-operation: any in-flight request is abandoned. A late response arriving after reset falls in FETCH and is dropped; the first post-reset request goes to `RESET_PC`.
- A back-to-back `instr_ready` held high causes no double-count: `fetch_count` increments once per HOLD exit.
- `Op` is registered from IR (no path from `imem_rsp_data`), so `Branch` is a one-level combinational path through the decoder.

## Test plan
- **Reset and sequential fetch.** Reset released with `RESET_PC`=0, memory always ready with 1-cycle responses, `instr_ready`=1 -> request addresses 0x0, 0x4, 0x8, 0xC, one every 3 cycles; `fetch_count`=4 after the fourth acceptance; `Op`=6'b111111 whenever `instr_valid`=0.
- **Taken backward branch.** beq at 0x10 with IR[15:0]=0xFFFF, `Branch`=1, `Zero`=1 -> next request at 0x10; with IR[15:0]=0x0003 -> next request at 0x20.
- **Not-taken branch and non-branch.** `Branch`=1, `Zero`=0 at 0x10 -> next request at 0x14. `Branch`=0, `Zero`=1 (lw, Op=6'b100011) -> 0x14.
- **Backpressure.**
  - Memory deasserts `imem_req_ready` for 4 cycles -> `imem_req_addr` is stable throughout.
  - `instr_ready` low for 5 cycles in HOLD -> `instr`, `Op` and `instr_pc` are unchanged, `fetch_count` is unchanged, and no new request is issued.
- **Stray response and reset mid-WAIT.**
  - `imem_rsp_valid` pulsed in FETCH -> ignored.
  - Reset asserted in WAIT with pc=0x40 -> `instr_valid`=0; the late response is dropped; the next request goes to `RESET_PC`.
- **Wrap and fetch_en.**
  - pc=0xFFFF_FFFC, sequential -> next address 0x0.
  - `fetch_count` at 0xFFFF plus one acceptance -> 0x0000.
  - `fetch_en`=0 in FETCH -> `imem_req_valid` stays 0 until `fetch_en` returns to 1.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bus bundle for the instruction fetch unit.
//   imem_req_*  : one-outstanding valid/ready read request to instruction memory
//   imem_rsp_*  : response (valid only, exactly one per accepted request)
//   instr_*, Op : held instruction presented to the decode stage (valid/ready)
// Modports:
//   master : the fetch unit (drives requests and the held instruction)
//   slave  : memory + decode side (drives ready/response signals)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int PC_W = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [PC_W-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic [5:0]      Op;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        output instr,
        output instr_pc,
        output Op,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        input  Op,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch sequencer for the MIPS datapath. Owns the PC, issues one outstanding
// word read to instruction memory, holds the returned word in the IR until
// decode accepts it, and picks the next PC from the decoder Branch output and
// the ALU Zero flag.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   fetch_en     : gates issue of new requests (in-flight fetch still completes)
//   bus          : instr_fetch_unit_if.master (imem request/response, held instr)
//   Branch, Zero : decoder/ALU feedback for the held instruction
//   fetch_count  : instructions accepted downstream, modulo 2^16
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_en,
    instr_fetch_unit_if.master  bus,
    input  logic                Branch,
    input  logic                Zero,
    output logic [15:0]         fetch_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic [PC_W-1:0] ir_pc;
    logic [15:0]     cnt;
    // Set while a request is presented but not yet accepted, so that a drop of
    // fetch_en cannot retract a pending request.
    logic            req_hold;

    logic            req_fire;
    logic            rsp_take;
    logic            instr_take;

    // Next PC: sequential, or sequential plus the sign-extended word offset.
    function automatic logic [PC_W-1:0] next_pc(
        input logic [PC_W-1:0] cur,
        input logic [15:0]     imm16,
        input logic            take
    );
        logic signed [15:0]     imm_s;
        logic signed [PC_W-1:0] off_s;
        logic [PC_W-1:0]        seq;
        imm_s = imm16;
        off_s = PC_W'(imm_s);
        seq   = cur + PC_W'(4);
        if (take) begin
            next_pc = seq + $unsigned(off_s <<< 2);
        end else begin
            next_pc = seq;
        end
    endfunction

    // Next-state and request outputs.
    always_comb begin
        state_nxt          = state;
        bus.imem_req_valid = 1'b0;
        bus.imem_req_addr  = pc;
        case (state)
            FETCH: begin
                bus.imem_req_valid = (fetch_en | req_hold) & ~reset;
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign req_fire   = bus.imem_req_valid & bus.imem_req_ready;
    assign rsp_take   = (state == WAIT) & bus.imem_rsp_valid;
    assign instr_take = (state == HOLD) & bus.instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_hold <= 1'b0;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            cnt      <= '0;
        end else begin
            req_hold <= bus.imem_req_valid & ~req_fire;
            if (rsp_take) begin
                ir    <= bus.imem_rsp_data;
                ir_pc <= pc;
            end
            // Branch/Zero only matter in the cycle the held instruction leaves.
            if (instr_take) begin
                pc  <= next_pc(ir_pc, ir[15:0], Branch & Zero);
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Op comes from the IR register only; a bubble opcode when nothing is held.
    assign bus.instr_valid = (state == HOLD);
    assign bus.instr       = ir;
    assign bus.instr_pc    = ir_pc;
    assign bus.Op          = (state == HOLD) ? ir[31:26] : 6'b111111;
    assign fetch_count     = cnt;

endmodule
